// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the single device memory port.
// Each grant issues one device strobe, waits out the read latency and returns a Done pulse.
module dev_bus_arbiter #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0Req,
  input  logic                  m0Lock,
  input  logic                  m0We,
  input  logic [ADDR_WIDTH-1:0] m0Addr,
  input  logic [DATA_WIDTH-1:0] m0Data,
  output logic [DATA_WIDTH-1:0] m0Q,
  output logic                  m0Done,

  input  logic                  m1Req,
  input  logic                  m1Lock,
  input  logic                  m1We,
  input  logic [ADDR_WIDTH-1:0] m1Addr,
  input  logic [DATA_WIDTH-1:0] m1Data,
  output logic [DATA_WIDTH-1:0] m1Q,
  output logic                  m1Done,

  output logic                  devClkEn,
  output logic                  devWriteEn,
  output logic [ADDR_WIDTH-1:0] devAddr,
  output logic [DATA_WIDTH-1:0] devData,
  input  logic [DATA_WIDTH-1:0] devQ,

  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

  state_e                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic                  lock_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  clk_en_q;
  logic                  dev_we_q;
  logic                  done0_q;
  logic                  done1_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] q0_q;
  logic [DATA_WIDTH-1:0] q1_q;

  logic                  grant_d;
  logic                  owner_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [1:0]            req;

  assign req = {m1Req, m0Req};

  // Grant decision for the IDLE cycle: lock hold first, then round-robin on a tie.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grant_d = 1'b0;
    owner_d = owner_q;
    if (lock_q && req[owner_q]) begin
      grant_d = 1'b1;
      owner_d = owner_q;
    end else if (req == 2'b11) begin
      grant_d = 1'b1;
      owner_d = ~last_q;
    end else if (req[0]) begin
      grant_d = 1'b1;
      owner_d = 1'b0;
    end else if (req[1]) begin
      grant_d = 1'b1;
      owner_d = 1'b1;
    end
    we_d   = owner_d ? m1We   : m0We;
    addr_d = owner_d ? m1Addr : m0Addr;
    data_d = owner_d ? m1Data : m0Data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      lock_q   <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      clk_en_q <= 1'b0;
      dev_we_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      q0_q     <= '0;
      q1_q     <= '0;
    end else begin
      clk_en_q <= 1'b0;
      dev_we_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A recorded lock only matters on the first IDLE cycle after its RESP.
          lock_q <= 1'b0;
          if (grant_d) begin
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            clk_en_q <= 1'b1;
            dev_we_q <= we_d;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            {done1_q, done0_q} <= owner_q ? 2'b10 : 2'b01;
            state_q            <= ST_RESP;
          end else begin
            cnt_q   <= WAIT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            if (owner_q) q1_q <= devQ;
            else         q0_q <= devQ;
            {done1_q, done0_q} <= owner_q ? 2'b10 : 2'b01;
            state_q            <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          last_q  <= owner_q;
          lock_q  <= owner_q ? m1Lock : m0Lock;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0Q        = q0_q;
  assign m1Q        = q1_q;
  assign m0Done     = done0_q;
  assign m1Done     = done1_q;
  assign devClkEn   = clk_en_q;
  assign devWriteEn = dev_we_q;
  assign devAddr    = addr_q;
  assign devData    = data_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule
